// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and helpers for the vending transaction sequencer.
//               Holds the controller state enum, the coin encoding, the
//               coin-to-cents mapping and the greedy change-coin selector.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int CREDIT_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        COLLECT  = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } vend_state_t;

    localparam logic [1:0] COIN_5   = 2'd0;
    localparam logic [1:0] COIN_10  = 2'd1;
    localparam logic [1:0] COIN_25  = 2'd2;
    localparam logic [1:0] COIN_100 = 2'd3;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        logic [6:0] v;
        case (code)
            COIN_5:   v = 7'd5;
            COIN_10:  v = 7'd10;
            COIN_25:  v = 7'd25;
            default:  v = 7'd100;
        endcase
        return v;
    endfunction

    // Largest coin not exceeding the amount; amounts below 5 map to COIN_5
    // and are handled by the caller as a leftover to discard.
    function automatic logic [1:0] greedy_coin(input int unsigned amount);
        logic [1:0] c;
        if (amount >= 100)     c = COIN_100;
        else if (amount >= 25) c = COIN_25;
        else if (amount >= 10) c = COIN_10;
        else                   c = COIN_5;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_controller_change_maker.sv
`default_nettype none
// ============================================================================
// Module      : change_maker
// Description : Pays out an amount as a greedy coin sequence (100/25/10/5)
//               over the change_valid/change_ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   load, amount    : start a payout of 'amount' cents
//   change_ready    : hopper ejected the presented coin
//   change_valid    : a coin is being requested
//   change_coin     : coin to eject, stable until accepted
//   done            : payout complete (same cycle as the final handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module change_maker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                change_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                done
);

    localparam logic [CREDIT_W-1:0] c_MIN_COIN = CREDIT_W'(5);

    logic [CREDIT_W-1:0] r_remaining;
    logic                r_valid;
    logic [1:0]          r_coin;
    logic                r_flush;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_next;
    logic                w_handshake;
    logic                w_last;

    // The greedy coin never exceeds the remaining amount, so w_next cannot wrap.
    assign w_coin_val  = CREDIT_W'(coin_value(r_coin));
    assign w_next      = r_remaining - w_coin_val;
    assign w_handshake = r_valid && change_ready;
    assign w_last      = w_handshake && (w_next < c_MIN_COIN);

    // r_flush covers a sub-5c load that has no coin to pay out.
    assign done         = w_last || r_flush;
    assign change_valid = r_valid;
    assign change_coin  = r_coin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_coin      <= COIN_5;
            r_flush     <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (load) begin
                if (amount >= c_MIN_COIN) begin
                    r_remaining <= amount;
                    r_valid     <= 1'b1;
                    r_coin      <= greedy_coin(32'(amount));
                end else begin
                    r_remaining <= '0;
                    r_valid     <= 1'b0;
                    r_coin      <= COIN_5;
                    r_flush     <= 1'b1;
                end
            end else if (w_handshake) begin
                if (w_last) begin
                    // Any sub-5c residue is unreachable with legal prices; drop it.
                    r_remaining <= '0;
                    r_valid     <= 1'b0;
                    r_coin      <= COIN_5;
                end else begin
                    r_remaining <= w_next;
                    r_coin      <= greedy_coin(32'(w_next));
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller
// Description : Vending transaction sequencer. Latches a selection, looks up
//               its price, accumulates coins, dispenses the item and pays
//               change, or refunds on cancel / inactivity timeout.
//   clk, rst                       : clock, asynchronous active-high reset
//   sel_valid, sel_code            : keypad selection pulse and code
//   coin_valid, coin_type          : coin acceptor pulse and denomination
//   cancel                         : customer abort pulse
//   price_sel / price_in           : price lookup request / response
//   sel_error, coin_reject         : registered one-cycle error pulses
//   credit                         : current credit in cents
//   dispense_valid/_code/_ready    : dispenser handshake
//   change_valid/_coin/_ready      : change hopper handshake
//   busy                           : transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT     = 500,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CREDIT_W       = CREDIT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [5:0]          sel_code,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic [5:0]          price_sel,
    input  logic [8:0]          price_in,
    output logic                sel_error,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_valid,
    output logic [5:0]          dispense_code,
    input  logic                dispense_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    input  logic                change_ready,
    output logic                busy
);

    localparam int                   c_TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CREDIT_W:0]    c_MAX        = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_t          r_state;
    logic [5:0]           r_code;
    logic [CREDIT_W-1:0]  r_price;
    logic [CREDIT_W-1:0]  r_credit;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_sel_error;
    logic                 r_coin_reject;
    logic [5:0]           r_price_sel;
    logic                 r_dispense_valid;
    logic [5:0]           r_dispense_code;

    logic [CREDIT_W:0]    w_sum;
    logic                 w_accept;
    logic [CREDIT_W-1:0]  w_new_credit;
    logic                 w_abort;
    logic [CREDIT_W-1:0]  w_change;
    logic                 w_load;
    logic [CREDIT_W-1:0]  w_load_amt;
    logic                 w_change_done;

    // One extra bit on the sum so the MAX_CREDIT compare sees true magnitude.
    assign w_sum        = {1'b0, r_credit} + (CREDIT_W + 1)'(coin_value(coin_type));
    assign w_accept     = coin_valid && (w_sum <= c_MAX);
    assign w_new_credit = w_accept ? w_sum[CREDIT_W-1:0] : r_credit;
    // An accepted coin restarts the inactivity window, so it also defers a timeout.
    assign w_abort      = cancel || (!w_accept && (r_timer == c_TIMER_LAST));
    assign w_change     = (r_credit >= r_price) ? (r_credit - r_price) : '0;

    // The load is combinational so the first change coin is presented in the
    // same cycle the state becomes CHANGE.
    always_comb begin
        w_load     = 1'b0;
        w_load_amt = '0;
        case (r_state)
            COLLECT: begin
                if (w_abort && (w_new_credit != '0)) begin
                    w_load     = 1'b1;
                    w_load_amt = w_new_credit;
                end
            end
            DISPENSE: begin
                if (dispense_ready && (w_change != '0)) begin
                    w_load     = 1'b1;
                    w_load_amt = w_change;
                end
            end
            default: begin
                w_load     = 1'b0;
                w_load_amt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_code           <= '0;
            r_price          <= '0;
            r_credit         <= '0;
            r_timer          <= '0;
            r_sel_error      <= 1'b0;
            r_coin_reject    <= 1'b0;
            r_price_sel      <= '0;
            r_dispense_valid <= 1'b0;
            r_dispense_code  <= '0;
        end else begin
            r_sel_error   <= sel_valid && (r_state != IDLE);
            r_coin_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_coin_reject <= coin_valid;
                    if (sel_valid && (sel_code != 6'd0)) begin
                        r_code      <= sel_code;
                        r_price_sel <= sel_code;
                        r_state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_coin_reject <= coin_valid;
                    r_price_sel   <= '0;
                    if (price_in == 9'd0) begin
                        r_sel_error <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_price <= CREDIT_W'(price_in);
                        r_timer <= '0;
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    r_coin_reject <= coin_valid && !w_accept;
                    r_timer       <= w_accept ? '0 : (r_timer + c_TIMER_W'(1));
                    if (w_abort) begin
                        r_credit <= '0;
                        r_state  <= (w_new_credit != '0) ? CHANGE : IDLE;
                    end else if (w_new_credit >= r_price) begin
                        r_credit         <= w_new_credit;
                        r_dispense_valid <= 1'b1;
                        r_dispense_code  <= r_code;
                        r_state          <= DISPENSE;
                    end else begin
                        r_credit <= w_new_credit;
                    end
                end
                DISPENSE: begin
                    r_coin_reject <= coin_valid;
                    if (dispense_ready) begin
                        r_dispense_valid <= 1'b0;
                        r_dispense_code  <= '0;
                        r_credit         <= '0;
                        r_state          <= (w_change != '0) ? CHANGE : IDLE;
                    end
                end
                CHANGE: begin
                    r_coin_reject <= coin_valid;
                    if (w_change_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    change_maker #(
        .CREDIT_W (CREDIT_W)
    ) u_change_maker (
        .clk          (clk),
        .rst          (rst),
        .load         (w_load),
        .amount       (w_load_amt),
        .change_ready (change_ready),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .done         (w_change_done)
    );

    assign price_sel      = r_price_sel;
    assign sel_error      = r_sel_error;
    assign coin_reject    = r_coin_reject;
    assign credit         = r_credit;
    assign dispense_valid = r_dispense_valid;
    assign dispense_code  = r_dispense_code;
    assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_controller
// Description : Self-checking bench for vend_controller. A transaction-level
//               model (credit as an integer, change as a precomputed coin
//               queue) is stepped every cycle and compared to the outputs;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    localparam int c_MAX = 500;
    localparam int c_TMO = 16;
    localparam int c_CW  = 10;

    localparam int P_IDLE = 0, P_LOOKUP = 1, P_COLLECT = 2, P_DISPENSE = 3, P_CHANGE = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sel_valid = 1'b0;
    logic [5:0]      sel_code = '0;
    logic            coin_valid = 1'b0;
    logic [1:0]      coin_type = '0;
    logic            cancel = 1'b0;
    logic [5:0]      price_sel;
    logic [8:0]      price_in;
    logic            sel_error;
    logic            coin_reject;
    logic [c_CW-1:0] credit;
    logic            dispense_valid;
    logic [5:0]      dispense_code;
    logic            dispense_ready = 1'b0;
    logic            change_valid;
    logic [1:0]      change_coin;
    logic            change_ready = 1'b0;
    logic            busy;

    int checks = 0;
    int errors = 0;

    vend_controller #(
        .MAX_CREDIT     (c_MAX),
        .TIMEOUT_CYCLES (c_TMO),
        .CREDIT_W       (c_CW)
    ) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_code(sel_code),
        .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
        .price_sel(price_sel), .price_in(price_in), .sel_error(sel_error),
        .coin_reject(coin_reject), .credit(credit), .dispense_valid(dispense_valid),
        .dispense_code(dispense_code), .dispense_ready(dispense_ready),
        .change_valid(change_valid), .change_coin(change_coin),
        .change_ready(change_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Snack_selector stand-in.
    function automatic logic [8:0] price_of(input logic [5:0] code);
        case (code)
            6'd18:   return 9'd400;
            6'd42:   return 9'd150;
            6'd20:   return 9'd175;
            6'd10:   return 9'd200;
            6'd30:   return 9'd500;
            default: return 9'd0;
        endcase
    endfunction
    assign price_in = price_of(price_sel);

    function automatic int cents(input logic [1:0] c);
        case (c)
            2'd0:    return 5;
            2'd1:    return 10;
            2'd2:    return 25;
            default: return 100;
        endcase
    endfunction

    function automatic int code_of(input int c);
        case (c)
            100:     return 3;
            25:      return 2;
            10:      return 1;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_code, m_price, m_credit, m_timer;
    int m_q[$];
    bit e_sel_error, e_coin_reject;

    task automatic make_change(input int amt);
        int denoms[4] = '{100, 25, 10, 5};
        m_q.delete();
        foreach (denoms[k]) begin
            while (amt >= denoms[k]) begin
                m_q.push_back(denoms[k]);
                amt -= denoms[k];
            end
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_code = 0; m_price = 0; m_credit = 0; m_timer = 0;
        m_q.delete();
        e_sel_error = 0; e_coin_reject = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit tmo;
        e_sel_error   = sel_valid && (m_phase != P_IDLE);
        e_coin_reject = coin_valid && (m_phase != P_COLLECT);
        case (m_phase)
            P_IDLE: begin
                if (sel_valid && sel_code != 0) begin
                    m_code  = int'(sel_code);
                    m_phase = P_LOOKUP;
                end
            end
            P_LOOKUP: begin
                m_price = int'(price_of(6'(m_code)));
                if (m_price == 0) begin
                    e_sel_error = 1;
                    m_phase     = P_IDLE;
                end else begin
                    m_timer = 0;
                    m_phase = P_COLLECT;
                end
            end
            P_COLLECT: begin
                acc = 0;
                if (coin_valid) begin
                    if (m_credit + cents(coin_type) <= c_MAX) begin
                        m_credit += cents(coin_type);
                        acc = 1;
                    end else begin
                        e_coin_reject = 1;
                    end
                end
                tmo     = !acc && (m_timer == c_TMO - 1);
                m_timer = acc ? 0 : m_timer + 1;
                if (cancel || tmo) begin
                    make_change(m_credit);
                    m_phase  = (m_credit != 0) ? P_CHANGE : P_IDLE;
                    m_credit = 0;
                end else if (m_credit >= m_price) begin
                    m_phase = P_DISPENSE;
                end
            end
            P_DISPENSE: begin
                if (dispense_ready) begin
                    make_change(m_credit - m_price);
                    m_phase  = (m_credit != m_price) ? P_CHANGE : P_IDLE;
                    m_credit = 0;
                end
            end
            default: begin
                if (change_ready && m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = P_IDLE;
                end
            end
        endcase
    endtask

    // Compare process: inputs change only at negedge+1, so at each negedge the
    // applied inputs are exactly those the DUT sampled on the previous posedge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            else     model_step();
            check("sel_error",      int'(sel_error),      int'(e_sel_error));
            check("coin_reject",    int'(coin_reject),    int'(e_coin_reject));
            check("credit",         int'(credit),         m_credit);
            check("price_sel",      int'(price_sel),      (m_phase == P_LOOKUP) ? m_code : 0);
            check("dispense_valid", int'(dispense_valid), int'(m_phase == P_DISPENSE));
            check("dispense_code",  int'(dispense_code),  (m_phase == P_DISPENSE) ? m_code : 0);
            check("change_valid",   int'(change_valid),   int'(m_phase == P_CHANGE));
            check("change_coin",    int'(change_coin),
                  (m_phase == P_CHANGE && m_q.size() > 0) ? code_of(m_q[0]) : 0);
            check("busy",           int'(busy),           int'(m_phase != P_IDLE));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_sel(input int c);
        sel_valid = 1'b1; sel_code = 6'(c);
        tick();
        sel_valid = 1'b0; sel_code = '0;
    endtask

    task automatic do_coin(input int t);
        coin_valid = 1'b1; coin_type = 2'(t);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic dispense_handshake();
        dispense_ready = 1'b1;
        tick();
        dispense_ready = 1'b0;
    endtask

    task automatic collect_change(input string name, input int exp_sum, input int exp_n);
        int  sum = 0;
        int  n = 0;
        bit  saw_disp = 0;
        change_ready = 1'b1;
        for (int i = 0; i < 40 && busy; i++) begin
            if (change_valid) begin
                sum += cents(change_coin);
                n++;
            end
            if (dispense_valid) saw_disp = 1;
            tick();
        end
        change_ready = 1'b0;
        check({name, "_done"}, int'(busy), 0);
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_coins"}, n, exp_n);
        check({name, "_no_dispense"}, int'(saw_disp), 0);
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_credit", int'(credit), 0);

        // Coin in IDLE rejected; zero selection ignored.
        do_coin(3);
        check("idle_coin_reject", int'(coin_reject), 1);
        do_sel(0);
        check("sel0_ignored_busy", int'(busy), 0);

        // 1: exact payment, no change.
        do_sel(18); tick();
        repeat (4) do_coin(3);
        check("t1_dispense_valid", int'(dispense_valid), 1);
        check("t1_dispense_code", int'(dispense_code), 18);
        check("t1_credit", int'(credit), 400);
        dispense_handshake();
        check("t1_idle", int'(busy), 0);
        check("t1_no_change", int'(change_valid), 0);
        check("t1_credit0", int'(credit), 0);

        // 2: overpay, 50c change as two 25c coins.
        do_sel(42); tick();
        do_coin(3); do_coin(3);
        check("t2_dispense_code", int'(dispense_code), 42);
        dispense_handshake();
        check("t2_first_coin", int'(change_coin), 2);
        collect_change("t2_change", 50, 2);

        // 3: zero-price selection.
        do_sel(1);
        check("t3_lookup_busy", int'(busy), 1);
        check("t3_no_err_yet", int'(sel_error), 0);
        tick();
        check("t3_sel_error", int'(sel_error), 1);
        check("t3_idle", int'(busy), 0);

        // 4: cancel refunds; selection in COLLECT flagged.
        do_sel(20); tick();
        do_coin(2); do_coin(1);
        check("t4_credit", int'(credit), 35);
        do_sel(5);
        check("t4_sel_in_collect", int'(sel_error), 1);
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("t4_refund_coin", int'(change_coin), 2);
        check("t4_credit0", int'(credit), 0);
        collect_change("t4_refund", 35, 2);
        do_sel(20); tick();
        do_coin(2);
        cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'd1;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        collect_change("t4_refund_with_coin", 35, 2);

        // 5: coins while dispensing, and the MAX_CREDIT boundary.
        do_sel(18); tick();
        repeat (4) do_coin(3);
        do_coin(3);
        check("t5_reject_in_dispense", int'(coin_reject), 1);
        check("t5_credit_held", int'(credit), 400);
        dispense_handshake();
        do_sel(30); tick();
        repeat (4) do_coin(3);
        do_coin(2); do_coin(2);
        check("t5_credit450", int'(credit), 450);
        do_coin(3);
        check("t5_over_max_reject", int'(coin_reject), 1);
        check("t5_credit_still450", int'(credit), 450);
        do_coin(2); do_coin(2);
        check("t5_credit_at_max", int'(credit), 500);
        check("t5_dispense_at_max", int'(dispense_valid), 1);
        dispense_handshake();
        check("t5_idle", int'(busy), 0);

        // 6: inactivity timeout refund, then reset during CHANGE.
        do_sel(10); tick();
        do_coin(2);
        repeat (c_TMO - 1) tick();
        check("t6_before_timeout", int'(change_valid), 0);
        check("t6_credit_kept", int'(credit), 25);
        tick();
        check("t6_timeout_refund", int'(change_valid), 1);
        check("t6_refund_coin", int'(change_coin), 2);
        check("t6_credit0", int'(credit), 0);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_change_valid", int'(change_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_coin", int'(change_coin), 0);
        tick();
        rst = 1'b0;
        tick();
        do_sel(42); tick();
        do_coin(3); do_coin(3);
        check("t6_post_reset_credit", int'(credit), 200);
        dispense_handshake();
        collect_change("t6_post_change", 50, 2);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Transaction sequencer for the vending machine. Accepts a snack selection, queries the Snack_selector price lookup and accumulates inserted coins. It then dispenses the item and pays out change as a greedy coin sequence, or refunds on cancel or timeout. It sits between the keypad/coin-acceptor front end and the dispenser/change-hopper actuators. Snack_selector is instantiated beside it at top level.

Parameters:
MAX_CREDIT, 500, highest credit in cents the machine will hold; a coin that would exceed it is rejected.
TIMEOUT_CYCLES, 50_000_000, number of idle cycles in COLLECT before an automatic refund.
CREDIT_W, 10, credit and change register width in bits; must hold MAX_CREDIT.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
sel_valid  in  1  one-cycle pulse: sel_code is valid
sel_code  in  6  keypad selection; 0 means none
coin_valid  in  1  one-cycle pulse: a coin was inserted
coin_type  in  2  0 = 5c, 1 = 10c, 2 = 25c, 3 = 100c
cancel  in  1  one-cycle pulse: customer abort
price_sel  out  6  selection code driven to Snack_selector
price_in  in  9  price in cents returned combinationally by Snack_selector
sel_error  out  1  one-cycle pulse: selection has price 0, or selection arrived outside IDLE
coin_reject  out  1  one-cycle pulse: coin not accepted; the acceptor returns it physically
credit  out  CREDIT_W  current credit in cents
dispense_valid  out  1  dispense request
dispense_code  out  6  item to dispense; held stable while dispense_valid=1
dispense_ready  in  1  dispenser accepts the request
change_valid  out  1  change-coin request
change_coin  out  2  coin to eject, same encoding as coin_type
change_ready  in  1  hopper ejected the coin
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE. credit, price register, change register, timer and every output go to 0. Any in-flight credit is discarded.
- IDLE:
  - sel_valid with sel_code!=0: latch sel_code, go to LOOKUP.
  - sel_valid with sel_code=0: ignored.
  - coin_valid: coin_reject=1.
- LOOKUP (exactly 1 cycle):
  - price_sel=latched code.
  - price_in==0: sel_error=1, go to IDLE.
  - otherwise: register price, go to COLLECT.
  - price_sel is 0 in every state other than LOOKUP.
- COLLECT:
  - Coin handling: if credit+value<=MAX_CREDIT, credit+=value; otherwise coin_reject=1.
  - Timer clears on entry and on every accepted coin, and increments otherwise.
  - Priority within a cycle: the coin is applied first, then cancel or timeout is evaluated, then the credit>=price check.
  - cancel=1, or timer==TIMEOUT_CYCLES-1: change register=credit (including a coin accepted that cycle), credit=0, go to CHANGE (or IDLE if the amount is 0). Cancel takes priority over dispense in the same cycle.
  - Otherwise, if the updated credit>=price: go to DISPENSE.
  - sel_valid in COLLECT: ignored, sel_error=1.
- DISPENSE:
  - dispense_valid=1, dispense_code=latched code.
  - Hold until dispense_ready=1; that cycle is the handshake.
  - On the handshake: change register=credit-price, credit=0, go to CHANGE if the change is non-zero, else IDLE.
  - cancel is ignored in this state.
- CHANGE:
  - change_valid=1. change_coin=largest coin <= remaining amount, in order 100, 25, 10, 5.
  - On change_ready: remaining -= coin value. When remaining reaches 0, go to IDLE in the same cycle.
  - If remaining is non-zero and below 5 (unreachable with legal prices): clear it and go to IDLE.
  - change_coin is stable while change_valid=1 and change_ready=0.
- coin_valid in LOOKUP, DISPENSE or CHANGE: coin_reject=1, credit unchanged.
- Arithmetic:
  - All additions are CREDIT_W+1 bits wide before the MAX_CREDIT compare, so overflow cannot occur.
  - The 9-bit price is zero-extended.
  - Subtraction happens only when credit>=price.
- All pulse outputs (sel_error, coin_reject) are registered, asserted 1 cycle after the causing input, high for exactly 1 cycle.

Decomposition:
- Package vend_pkg holds:
  - the state enum (IDLE, LOOKUP, COLLECT, DISPENSE, CHANGE)
  - coin encoding constants COIN_5, COIN_10, COIN_25, COIN_100
  - a coin_value function mapping 2-bit code to cents
  - CREDIT_W default
- One sub-module, change_maker. It owns the remaining-amount register, greedy coin selection and the change_valid/change_ready handshake. It takes a load pulse with the amount and returns a done pulse.

Test Plan:
1. sel_code=18 (price 400); four 100c coins -> dispense_valid with code 18 after the 4th coin; ready -> no change_valid; back to IDLE; credit=0.
2. sel_code=42 (price 150); two 100c coins -> dispense code 42; then change_valid twice with change_coin=25 (total 50c); IDLE.
3. sel_code=1 (price 0) -> sel_error pulse 2 cycles after sel_valid; state IDLE; busy=0.
4. sel_code=20 (175); coins 25+10; cancel -> change 25 then 10, no dispense; cancel and coin in the same cycle -> refund includes that coin.
5. sel_code=18 (400); insert 100c x4 with dispense_ready held low, then try a 5th coin -> coin_reject=1, credit stays 400. Separately, with credit 450 and MAX_CREDIT 500, a 100c coin -> coin_reject=1.
6. TIMEOUT_CYCLES=16; select 10 (200); one 25c coin; idle 16 cycles -> automatic refund of 25c. Assert rst mid-CHANGE -> all outputs 0 immediately and IDLE.
